intercal_alu_sequencer: RTL
===========================

Name: intercal_alu_sequencer

Overview:
- Byte-serial front/back end for the combinational INTERCAL ALU.
- Collects an opcode, a 32-bit operand A and a 32-bit operand B from an 8-bit valid/ready stream, and presents them stable to the ALU.
- Captures the ALU result one cycle later and streams it back out as bytes on a second valid/ready port.
- Replaces raw per-byte register pokes with a flow-controlled sequence for the pad-limited top level.

Parameters:
- NBYTES, 4, bytes per operand and per result; operand width is 8*NBYTES.
- OP_W, 4, opcode width passed to the ALU.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- cmd_op  input  OP_W  opcode; sampled together with the first byte of A.
- in_data  input  8  operand byte stream, LSB first, A before B.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept a byte.
- alu_op  output  OP_W  latched opcode to the ALU.
- alu_a  output  8*NBYTES  operand A to the ALU.
- alu_b  output  8*NBYTES  operand B to the ALU.
- alu_f  input  8*NBYTES  ALU result (combinational from alu_op/alu_a/alu_b).
- out_data  output  8  result byte stream, LSB first.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in any state other than LOAD_A with byte count 0.

Behaviour:
- States: LOAD_A, LOAD_B, EXEC, SEND (plus CSUM when the optional feature is enabled).
- Byte counter cnt: ceil(log2(NBYTES+1)) bits.
- Reset (rst_n low at a clock edge):
  - state=LOAD_A, cnt=0.
  - alu_a, alu_b, alu_op and the result register are 0.
  - out_valid=0, in_ready=1 in the cycle after the reset edge.
- Reset mid-operation: any partial operand or unsent result is discarded; no further out_valid.
- in_ready is 1 only in LOAD_A/LOAD_B. It is a pure function of state, independent of in_valid.
- Input transfer occurs when in_valid & in_ready at a clock edge:
  - LOAD_A: byte written to alu_a[8*cnt+7:8*cnt]. When cnt==0, cmd_op is also latched into alu_op. cnt increments; at cnt==NBYTES-1, cnt resets to 0 and state goes to LOAD_B.
  - LOAD_B: same, into alu_b. After the last byte, state goes to EXEC.
- in_valid low: no state change (bubbles allowed anywhere).
- EXEC: exactly one cycle. At its closing edge, alu_f is captured into the result register and state goes to SEND with cnt=0.
- alu_a, alu_b and alu_op hold their values through EXEC and SEND. They change only on input transfers.
- SEND:
  - out_valid=1; out_data = result[8*cnt+7:8*cnt].
  - On out_valid & out_ready, cnt increments.
  - After the last byte, state goes to LOAD_A with cnt=0 and out_valid drops in the next cycle.
  - out_data is stable while out_valid & !out_ready.
- Latency: last B byte accepted at edge N. EXEC runs during cycle N..N+1, result is captured at edge N+1, and out_valid is first high after edge N+1. Minimum 2*NBYTES + 1 + NBYTES cycles per operation.
- No overlap: the next A byte is not accepted until the final result byte has transferred. in_ready rises the cycle after that transfer.
- No overflow or width effects: operands and result are fixed-width. Unused opcode values are passed through unchanged.

Optional Feature:
- Macro INTERCAL_ALU_SEQ_CHECKSUM_EN.
- Defined:
  - After the last result byte, state goes to CSUM.
  - CSUM emits one extra byte equal to the XOR of all NBYTES result bytes, same valid/ready rules, then goes to LOAD_A.
- Undefined: the CSUM state and XOR logic are absent; SEND goes directly to LOAD_A.

Decomposition:
- Package intercal_alu_seq_pkg:
  - state enum (LOAD_A, LOAD_B, EXEC, SEND, CSUM);
  - BYTE_W=8;
  - default OP_W and NBYTES constants.
- No sub-module is needed: the FSM, operand registers and result register live in one module.
- The ALU itself is instantiated by the top level, not inside this block.

Test Plan:
- Bench ALU model: alu_f = alu_a ^ alu_b.
- Basic: cmd_op=4'h3, bytes 78 56 34 12 EF BE AD DE streamed back-to-back with out_ready=1 -> alu_op=3, alu_a=32'h12345678, alu_b=32'hDEADBEEF; out bytes 97 E8 99 CC; in_ready returns high after the 4th.
- Input bubbles: same bytes with in_valid toggling 1/0 -> identical result bytes; cnt does not advance on idle cycles.
- Output backpressure: out_ready low for 3 cycles on byte 1 -> out_data holds E8 with out_valid=1 throughout; no byte is skipped or repeated.
- Reset mid-load: rst_n low after 6 input bytes -> alu_a=alu_b=0, state LOAD_A. A fresh full sequence then gives a correct result.
- Opcode sampling: cmd_op changes from 1 to 7 after the first A byte -> alu_op stays 1 until the next operation's first byte.
- With INTERCAL_ALU_SEQ_CHECKSUM_EN, basic stimulus -> 5th byte = 97^E8^99^CC = 0x2A; without the macro, only 4 bytes are sent.

Source files
------------

// File: rtl/intercal_alu_seq_pkg.sv
// Shared types and constants for the INTERCAL ALU byte-serial sequencer.
package intercal_alu_seq_pkg;

  localparam int BYTE_W     = 8;
  localparam int DEF_OP_W   = 4;
  localparam int DEF_NBYTES = 4;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    EXEC   = 3'd2,
    SEND   = 3'd3,
    CSUM   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/intercal_alu_sequencer.sv
// Byte-serial front/back end for the combinational INTERCAL ALU.
// Optional trailing XOR checksum byte: define INTERCAL_ALU_SEQ_CHECKSUM_EN.
//
// state  | meaning
// LOAD_A | accepting operand A bytes, LSB first; opcode latched with byte 0
// LOAD_B | accepting operand B bytes, LSB first
// EXEC   | one cycle for the ALU to settle; result captured on exit
// SEND   | streaming result bytes, LSB first
// CSUM   | streaming XOR of the result bytes (checksum build only)
module intercal_alu_sequencer
  import intercal_alu_seq_pkg::*;
#(
  parameter int NBYTES = DEF_NBYTES,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OP_W-1:0]          cmd_op,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OP_W-1:0]          alu_op,
  output logic [BYTE_W*NBYTES-1:0] alu_a,
  output logic [BYTE_W*NBYTES-1:0] alu_b,
  input  logic [BYTE_W*NBYTES-1:0] alu_f,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  seq_state_e               state;
  logic [CNT_W-1:0]         cnt;
  logic [BYTE_W*NBYTES-1:0] res_q;
  logic [BYTE_W-1:0]        res_byte;

  assign res_byte = res_q[BYTE_W*int'(cnt) +: BYTE_W];

  // Handshake flags decode straight from registered state so they never
  // depend on the partner's valid/ready in the same cycle.
  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign busy     = !((state == LOAD_A) && (cnt == '0));

`ifdef INTERCAL_ALU_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NBYTES; i++) begin
      csum = csum ^ res_q[BYTE_W*i +: BYTE_W];
    end
  end

  assign out_valid = (state == SEND) || (state == CSUM);
  assign out_data  = (state == CSUM) ? csum : res_byte;
`else
  assign out_valid = (state == SEND);
  assign out_data  = res_byte;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LOAD_A;
      cnt    <= '0;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            alu_a[BYTE_W*int'(cnt) +: BYTE_W] <= in_data;
            if (cnt == '0) alu_op <= cmd_op;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            alu_b[BYTE_W*int'(cnt) +: BYTE_W] <= in_data;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= EXEC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EXEC: begin
          res_q <= alu_f;
          cnt   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef INTERCAL_ALU_SEQ_CHECKSUM_EN
              state <= CSUM;
`else
              state <= LOAD_A;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef INTERCAL_ALU_SEQ_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            cnt   <= '0;
            state <= LOAD_A;
          end
        end
`endif
        default: begin
          cnt   <= '0;
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule
